// File: rtl/fifo_pkg.sv
// Shared widths, FSM state type and lane-mask helper for the FIFO word packer.
package fifo_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WORD_W = BYTE_W * LANES;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 2;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Byte-enable mask covering the lanes below 'filled' (1 -> 0001, 2 -> 0011, 3 -> 0111).
  function automatic logic [LANES-1:0] lane_mask(input logic [IDX_W-1:0] filled);
    logic [LANES-1:0] m;
    m = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (l < 32'(filled)) m[l] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/packer_idle_timer.sv
// Idle-cycle counter for partial-word flush; expired marks the TIMEOUT-th consecutive idle cycle.
module packer_idle_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [7:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign expired = en && !clr && (r_cnt == 8'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Packs bytes popped from an upstream FIFO into 32-bit words with a valid/ready output.
// Optional partial-word flush after TIMEOUT idle cycles is compiled in by PACKER_TIMEOUT_EN.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  output logic [WORD_W-1:0] word_data,
  output logic [LANES-1:0]  word_be,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  word_cnt
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("fifo_word_packer: TIMEOUT must be within 2..255");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_data;
  logic [LANES-1:0]  r_be;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_pop;
  logic              w_xfer;
  logic              w_expired;

`ifdef PACKER_TIMEOUT_EN
  logic w_tmr_en;

  // Idle time only accumulates while a partial word is sitting in FILL.
  assign w_tmr_en = (r_state == FILL) && (r_idx != '0) && !w_pop;

  packer_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (w_tmr_en),
    .clr    (!w_tmr_en),
    .expired(w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      FILL: begin
        w_pop = !fifo_empty && !rst;
        if (w_pop && (r_idx == IDX_W'(LANES - 1))) begin
          w_state_nxt = HOLD;
        end else if (w_expired) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        w_xfer = r_valid && word_ready;
        if (w_xfer) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else if (w_xfer) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_be    <= '0;
      r_valid <= 1'b0;
      r_cnt   <= r_cnt + 1'b1;
    end else if (w_pop) begin
      r_data[BYTE_W*int'(r_idx) +: BYTE_W] <= fifo_data;
      r_idx <= r_idx + 1'b1;
      if (r_idx == IDX_W'(LANES - 1)) begin
        r_valid <= 1'b1;
        r_be    <= '1;
      end
    end else if (w_expired) begin
      r_valid <= 1'b1;
      r_be    <= lane_mask(r_idx);
    end
  end

  assign fifo_rd    = w_pop;
  assign word_data  = r_data;
  assign word_be    = r_be;
  assign word_valid = r_valid;
  assign word_cnt   = r_cnt;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed self-checking bench for fifo_word_packer; expectations follow PACKER_TIMEOUT_EN when defined.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fifo_data;
  logic        fifo_empty;
  logic        fifo_rd;
  logic [31:0] word_data;
  logic [3:0]  word_be;
  logic        word_valid;
  logic        word_ready;
  logic [15:0] word_cnt;

  logic [7:0] q[$];
  logic       rd_seen;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_pops   = 0;
  int         n_rd_empty = 0;
  int         n_rd_valid = 0;

  always #5 clk = ~clk;

  fifo_word_packer #(
    .TIMEOUT(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_data (fifo_data),
    .fifo_empty(fifo_empty),
    .fifo_rd   (fifo_rd),
    .word_data (word_data),
    .word_be   (word_be),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_cnt  (word_cnt)
  );

  task automatic refresh();
    fifo_empty = (q.size() == 0);
    fifo_data  = fifo_empty ? 8'h00 : q[0];
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  // One clock: sample pop strobe mid-cycle, then retire the popped byte just after the edge.
  task automatic tick();
    @(negedge clk);
    rd_seen = fifo_rd;
    if (fifo_rd && fifo_empty) n_rd_empty++;
    if (fifo_rd && word_valid) n_rd_valid++;
    @(posedge clk);
    #1;
    if (rd_seen && q.size() > 0) begin
      void'(q.pop_front());
      n_pops++;
    end
    refresh();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    word_ready = 1'b1;
    q.delete();
    push(8'h5A);
    tick();
    tick();
    n_checks++;
    if (rd_seen !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", rd_seen); end
    n_checks++;
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", word_valid); end
    n_checks++;
    if (word_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 00000000", word_data); end
    n_checks++;
    if (word_be !== 4'h0) begin n_fail++; $display("FAIL reset_be: got %b expected 0000", word_be); end
    n_checks++;
    if (word_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", word_cnt); end
    n_checks++;
    if (q.size() !== 1) begin n_fail++; $display("FAIL reset_nopop: got %0d bytes left expected 1", q.size()); end
    q.delete();
    refresh();
    rst = 1'b0;
  endtask

  task automatic test_single_word();
    int p0;
    p0 = n_pops;
    word_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (4) tick();
    n_checks++;
    if (n_pops - p0 !== 4) begin n_fail++; $display("FAIL single_pops: got %0d expected 4", n_pops - p0); end
    n_checks++;
    if (word_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", word_valid); end
    n_checks++;
    if (word_data !== 32'h44332211) begin n_fail++; $display("FAIL single_data: got %h expected 44332211", word_data); end
    n_checks++;
    if (word_be !== 4'hF) begin n_fail++; $display("FAIL single_be: got %b expected 1111", word_be); end
    tick();
    n_checks++;
    if (word_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b expected 0", word_valid); end
    n_checks++;
    if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL single_cnt: got %0d expected 1", word_cnt); end
    n_checks++;
    if (word_data !== 32'h0 || word_be !== 4'h0) begin
      n_fail++; $display("FAIL single_clear: got data %h be %b expected 00000000 0000", word_data, word_be);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    int bad;
    p0 = n_pops;
    bad = 0;
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'hA1 + 8'(i));
    repeat (4) tick();
    n_checks++;
    if (word_data !== 32'hA4A3A2A1 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_first: got data %h valid %b expected A4A3A2A1 1", word_data, word_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rd_seen !== 1'b0 || word_valid !== 1'b1 || word_data !== 32'hA4A3A2A1 || word_be !== 4'hF) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL bp_hold_stable: got %0d unstable cycles expected 0", bad); end
    n_checks++;
    if (n_pops - p0 !== 4) begin n_fail++; $display("FAIL bp_pops_held: got %0d expected 4", n_pops - p0); end
    word_ready = 1'b1;
    tick();
    n_checks++;
    if (rd_seen !== 1'b0) begin n_fail++; $display("FAIL bp_xfer_rd: got %b expected 0", rd_seen); end
    n_checks++;
    if (word_cnt !== 16'd2 || word_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_xfer: got cnt %0d valid %b expected 2 0", word_cnt, word_valid);
    end
    tick();
    n_checks++;
    if (rd_seen !== 1'b1) begin n_fail++; $display("FAIL bp_resume: got %b expected 1", rd_seen); end
    repeat (3) tick();
    n_checks++;
    if (word_data !== 32'hA8A7A6A5 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_second: got data %h valid %b expected A8A7A6A5 1", word_data, word_valid);
    end
    tick();
    n_checks++;
    if (word_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_cnt: got %0d expected 3", word_cnt); end
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    word_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (rd_seen !== 1'b0 || word_valid !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL idle_quiet: got %0d active cycles expected 0", bad); end
    n_checks++;
    if (word_cnt !== 16'd3) begin n_fail++; $display("FAIL idle_cnt: got %0d expected 3", word_cnt); end
  endtask

  task automatic test_partial();
    int cyc;
    word_ready = 1'b0;
    push(8'hAA); push(8'hBB);
    repeat (2) tick();
    cyc = 0;
    while (word_valid !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
`ifdef PACKER_TIMEOUT_EN
    n_checks++;
    if (cyc !== 16) begin n_fail++; $display("FAIL partial_latency: got %0d idle cycles expected 16", cyc); end
    n_checks++;
    if (word_data !== 32'h0000BBAA) begin n_fail++; $display("FAIL partial_data: got %h expected 0000BBAA", word_data); end
    n_checks++;
    if (word_be !== 4'b0011) begin n_fail++; $display("FAIL partial_be: got %b expected 0011", word_be); end
    push(8'hCC);
    repeat (2) tick();
    n_checks++;
    if (rd_seen !== 1'b0 || word_be !== 4'b0011) begin
      n_fail++; $display("FAIL partial_hold: got rd %b be %b expected 0 0011", rd_seen, word_be);
    end
    word_ready = 1'b1;
    tick();
    n_checks++;
    if (word_cnt !== 16'd4 || word_be !== 4'h0) begin
      n_fail++; $display("FAIL partial_xfer: got cnt %0d be %b expected 4 0000", word_cnt, word_be);
    end
    do_reset();
    q.delete();
    refresh();
`else
    n_checks++;
    if (cyc !== 40) begin n_fail++; $display("FAIL partial_no_flush: got valid after %0d cycles expected none", cyc); end
    push(8'hCC); push(8'hDD);
    repeat (2) tick();
    n_checks++;
    if (word_data !== 32'hDDCCBBAA || word_be !== 4'hF) begin
      n_fail++; $display("FAIL partial_complete: got data %h be %b expected DDCCBBAA 1111", word_data, word_be);
    end
    word_ready = 1'b1;
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    word_ready = 1'b1;
    push(8'hE1); push(8'hE2); push(8'hE3);
    repeat (3) tick();
    do_reset();
    n_checks++;
    if (word_cnt !== 16'd0 || word_data !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset_clear: got cnt %0d data %h expected 0 00000000", word_cnt, word_data);
    end
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    repeat (4) tick();
    n_checks++;
    if (word_data !== 32'h04030201 || word_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_word: got data %h valid %b expected 04030201 1", word_data, word_valid);
    end
    tick();
    n_checks++;
    if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_reset_cnt: got %0d expected 1", word_cnt); end
  endtask

  task automatic test_back_to_back();
    int p0;
    logic [31:0] exp_w;
    do_reset();
    p0 = n_pops;
    word_ready = 1'b1;
    for (int i = 0; i < 12; i++) push(8'(i + 1));
    for (int w = 0; w < 3; w++) begin
      repeat (4) tick();
      exp_w = {8'(4*w + 4), 8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1)};
      n_checks++;
      if (word_data !== exp_w || word_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_word%0d: got data %h valid %b expected %h 1", w, word_data, word_valid, exp_w);
      end
      tick();
      n_checks++;
      if (word_cnt !== 16'(w + 1)) begin n_fail++; $display("FAIL b2b_cnt%0d: got %0d expected %0d", w, word_cnt, w + 1); end
    end
    n_checks++;
    if (n_pops - p0 !== 12) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 12", n_pops - p0); end
  endtask

  initial begin
    rst = 1'b1;
    word_ready = 1'b0;
    refresh();
    test_reset();
    test_single_word();
    test_backpressure();
    test_idle();
    test_partial();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (n_rd_empty !== 0) begin n_fail++; $display("FAIL rd_while_empty: got %0d cycles expected 0", n_rd_empty); end
    n_checks++;
    if (n_rd_valid !== 0) begin n_fail++; $display("FAIL rd_while_valid: got %0d cycles expected 0", n_rd_valid); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
